// File: rtl/reverse_gather.sv
// Gathers RATIO narrow beats into one wide word, optionally bit-reversing it on
// output, with SOF-based realignment and a one-word output register.
module reverse_gather #(
    parameter int WIDTH    = 64,
    parameter int IN_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENA,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [IN_WIDTH-1:0] IN,
    input  logic                SOF,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [WIDTH-1:0]    OUT,
    output logic                ALIGN_ERR
);

    localparam int RATIO = WIDTH / IN_WIDTH;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    // Handshakes: a beat moves when IN_VALID && IN_READY at a rising edge; a
    // word leaves when OUT_VALID && OUT_READY. Nothing changes otherwise.
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    wr_idx;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_rev;
    logic             accept;
    logic             last;
    logic             trunc;
    logic             complete;

    assign last     = (cnt == LAST);
    assign IN_READY = !last || !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    // SOF mid-word restarts assembly, so it can never complete a word itself.
    assign trunc    = accept && SOF && (cnt != '0);
    assign complete = accept && last && !trunc;
    assign wr_idx   = trunc ? '0 : cnt;

    always_comb begin
        cnt_next = cnt + CW'(1);
        if (trunc) begin
            cnt_next = CW'(1);
        end else if (last) begin
            cnt_next = '0;
        end
    end

    // The final beat bypasses the assembly register straight into the word.
    always_comb begin
        word = asm_q;
        word[WIDTH-1 -: IN_WIDTH] = IN;
        word_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_rev[i] = word[WIDTH-1-i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            asm_q     <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            ALIGN_ERR <= trunc;
            if (accept) begin
                cnt <= cnt_next;
                for (int k = 0; k < RATIO; k++) begin
                    if (wr_idx == CW'(k)) begin
                        asm_q[k*IN_WIDTH +: IN_WIDTH] <= IN;
                    end
                end
            end
            if (complete) begin
                OUT       <= ENA ? word_rev : word;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reverse_gather.sv
// Directed bench for reverse_gather (WIDTH=64, IN_WIDTH=16): expected words are
// queued by the driver side and checked by an independent output monitor.
module tb_reverse_gather;

    localparam int W  = 64;
    localparam int IW = 16;

    logic          CLK;
    logic          RST_N;
    logic          ENA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [IW-1:0] IN;
    logic          SOF;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [W-1:0]  OUT;
    logic          ALIGN_ERR;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int words_seen = 0;
    int align_cnt = 0;
    int stall_seen = 0;
    bit prev_stall = 0;
    logic [W-1:0] prev_out = '0;

    reverse_gather #(.WIDTH(W), .IN_WIDTH(IW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .IN(IN), .SOF(SOF), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT(OUT), .ALIGN_ERR(ALIGN_ERR)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // driver: offers one beat, waits (bounded) for acceptance
    task automatic send_beat(input logic [IW-1:0] d, input bit s, input bit e);
        bit got = 0;
        int n = 0;
        IN_VALID = 1'b1;
        IN = d;
        SOF = s;
        ENA = e;
        while (!got && n < 50) begin
            @(negedge CLK);
            got = IN_READY;
            if (!IN_READY) stall_seen++;
            @(posedge CLK);
            #1;
            n++;
        end
        IN_VALID = 1'b0;
        SOF = 1'b0;
        ENA = 1'b0;
        if (!got) chk("beat_accept_timeout", 64'(d), 64'(d) ^ 64'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (RST_N) begin
            if (ALIGN_ERR) align_cnt++;
            if (OUT_VALID && OUT_READY) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", OUT, ~OUT);
                end else begin
                    chk("out_word", OUT, exp_q.pop_front());
                end
            end
            if (OUT_VALID && !OUT_READY) begin
                if (prev_stall) chk("stall_hold", OUT, prev_out);
                prev_stall = 1'b1;
                prev_out = OUT;
            end else begin
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        RST_N = 1'b0;
        ENA = 1'b0;
        IN_VALID = 1'b0;
        IN = '0;
        SOF = 1'b0;
        OUT_READY = 1'b1;
        #3;
        chk("reset_out_valid", 64'(OUT_VALID), 64'd0);
        chk("reset_out", OUT, 64'd0);
        chk("reset_align_err", 64'(ALIGN_ERR), 64'd0);
        chk("reset_in_ready", 64'(IN_READY), 64'd1);
        idle(2);
        RST_N = 1'b1;
        idle(1);

        // single word, no reversal; SOF on beat 0 is harmless
        exp_q.push_back(64'h0000_0000_0000_0001);
        send_beat(16'h0001, 1'b1, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        chk("valid_after_last_beat", 64'(OUT_VALID), 64'd1);
        idle(1);
        chk("valid_clears_after_take", 64'(OUT_VALID), 64'd0);

        // reversal only when ENA comes with the final beat
        exp_q.push_back(64'h8000_0000_0000_0000);
        send_beat(16'h0001, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b1);
        exp_q.push_back(64'h0000_0000_0000_0001);
        send_beat(16'h0001, 1'b0, 1'b1);
        send_beat(16'h0000, 1'b0, 1'b1);
        send_beat(16'h0000, 1'b0, 1'b1);
        send_beat(16'h0000, 1'b0, 1'b0);
        idle(2);

        // streaming at full rate
        stall_seen = 0;
        exp_q.push_back(64'h4444_3333_2222_1111);
        exp_q.push_back(64'h8888_7777_6666_5555);
        for (int i = 1; i <= 8; i++) send_beat(IW'(16'h1111 * i), 1'b0, 1'b0);
        chk("stream_in_ready_never_low", 64'(stall_seen), 64'd0);
        idle(2);

        // backpressure: pending word blocks the fourth beat of the next word
        OUT_READY = 1'b0;
        exp_q.push_back(64'h0708_0506_0304_0102);
        exp_q.push_back(64'h4040_3030_2020_1010);
        send_beat(16'h0102, 1'b0, 1'b0);
        send_beat(16'h0304, 1'b0, 1'b0);
        send_beat(16'h0506, 1'b0, 1'b0);
        send_beat(16'h0708, 1'b0, 1'b0);
        send_beat(16'h1010, 1'b0, 1'b0);
        send_beat(16'h2020, 1'b0, 1'b0);
        send_beat(16'h3030, 1'b0, 1'b0);
        IN_VALID = 1'b1;
        IN = 16'h4040;
        @(negedge CLK);
        chk("blocked_in_ready", 64'(IN_READY), 64'd0);
        chk("blocked_out_held", OUT, 64'h0708_0506_0304_0102);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("blocked_in_ready_2", 64'(IN_READY), 64'd0);
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("released_in_ready", 64'(IN_READY), 64'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk("back_to_back_valid", 64'(OUT_VALID), 64'd1);
        chk("back_to_back_word", OUT, 64'h4040_3030_2020_1010);
        idle(2);

        // SOF mid-word realigns
        exp_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
        send_beat(16'h5555, 1'b0, 1'b0);
        send_beat(16'h6666, 1'b0, 1'b0);
        send_beat(16'hAAAA, 1'b1, 1'b0);
        chk("align_err_pulse", 64'(ALIGN_ERR), 64'd1);
        send_beat(16'hBBBB, 1'b0, 1'b0);
        chk("align_err_one_cycle", 64'(ALIGN_ERR), 64'd0);
        send_beat(16'hCCCC, 1'b0, 1'b0);
        send_beat(16'hDDDD, 1'b0, 1'b0);
        idle(2);

        // reset with a pending word and a partial word
        OUT_READY = 1'b0;
        send_beat(16'h0009, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0000, 1'b0, 1'b0);
        send_beat(16'h0001, 1'b0, 1'b0);
        send_beat(16'h0002, 1'b0, 1'b0);
        send_beat(16'h0003, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("async_reset_valid", 64'(OUT_VALID), 64'd0);
        chk("async_reset_out", OUT, 64'd0);
        idle(1);
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        idle(1);
        exp_q.push_back(64'h00D4_00C3_00B2_00A1);
        send_beat(16'h00A1, 1'b0, 1'b0);
        send_beat(16'h00B2, 1'b0, 1'b0);
        send_beat(16'h00C3, 1'b0, 1'b0);
        send_beat(16'h00D4, 1'b0, 1'b0);
        idle(4);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("words_seen", 64'(words_seen), 64'd9);
        chk("align_err_total", 64'(align_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reverse_gather.md
REVERSE_GATHER -- requirements
Module: reverse_gather

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning assembled output word width in bits.
REQ-002 The block SHALL have parameter IN_WIDTH, default 16, meaning input beat width; WIDTH SHALL be an integer multiple of IN_WIDTH, and RATIO = WIDTH/IN_WIDTH SHALL be 2..16.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ENA, input, 1 bit: bit-reverse enable, sampled with the final beat of each word.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: input beat valid.
REQ-007 The block SHALL have port IN_READY, output, 1 bit: block can accept a beat this cycle.
REQ-008 The block SHALL have port IN, input, IN_WIDTH bits: input beat data.
REQ-009 The block SHALL have port SOF, input, 1 bit: the accompanying beat is beat 0 of a word.
REQ-010 The block SHALL have port OUT_VALID, output, 1 bit: OUT holds a complete word.
REQ-011 The block SHALL have port OUT_READY, input, 1 bit: downstream accepts the word.
REQ-012 The block SHALL have port OUT, output, WIDTH bits: assembled, optionally bit-reversed word.
REQ-013 The block SHALL have port ALIGN_ERR, output, 1 bit: one-cycle pulse when SOF truncates a partial word.

Function
REQ-014 A beat SHALL be accepted only in a cycle where IN_VALID=1 and IN_READY=1; no state SHALL change on unaccepted cycles.
REQ-015 Beat counter cnt (0..RATIO-1) SHALL increment on each accepted beat and wrap from RATIO-1 to 0.
REQ-016 Accepted beat k SHALL be stored at bits [IN_WIDTH*k +: IN_WIDTH] of the assembly register (first beat least significant).
REQ-017 IN_READY SHALL be combinational: 1 when cnt != RATIO-1, or OUT_VALID=0, or OUT_READY=1.
REQ-018 On acceptance of beat RATIO-1 (cycle n), the output register SHALL load the completed word, bit-reversed (OUT[i] = word[WIDTH-1-i]) if ENA=1 in cycle n, unmodified if ENA=0; OUT_VALID SHALL be 1 from cycle n+1.
REQ-019 OUT and OUT_VALID SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-020 When OUT_VALID=1 and OUT_READY=1 and no new word completes in that cycle, OUT_VALID SHALL clear next cycle.
REQ-021 When OUT_READY=1 and a word completes in the same cycle, the output register SHALL load the new word and OUT_VALID SHALL stay 1 (full throughput: one word per RATIO cycles with no bubbles).
REQ-022 SOF=1 on an accepted beat with cnt=0 SHALL have no extra effect.
REQ-023 SOF=1 on an accepted beat with cnt!=0 SHALL discard the partial word, store the beat as beat 0, set cnt to 1 (or complete the word immediately if RATIO were 1, not permitted), and pulse ALIGN_ERR=1 for exactly the next cycle.
REQ-024 SOF on an unaccepted cycle SHALL be ignored.
REQ-025 Unfilled assembly bits are don't-care; only complete words SHALL ever appear on OUT.

Reset
REQ-026 RST_N=0 SHALL asynchronously force cnt=0, OUT_VALID=0, OUT=0, ALIGN_ERR=0, assembly register=0.
REQ-027 Reset mid-word or with OUT_VALID=1 SHALL discard all partial and pending data; no word SHALL be emitted from pre-reset beats.
REQ-028 After RST_N deasserts, the first accepted beat SHALL be beat 0 regardless of SOF.

Verification (WIDTH=64, IN_WIDTH=16)
REQ-029 Beats 0x0001,0x0000,0x0000,0x0000, ENA=0, OUT_READY=1 -> OUT=0x0000_0000_0000_0001, OUT_VALID=1 one cycle after fourth beat.
REQ-030 Same beats with ENA=1 on fourth beat -> OUT=0x8000_0000_0000_0000; ENA toggled only on beats 0..2 -> no reversal.
REQ-031 Continuous IN_VALID=1, OUT_READY=1, 8 beats 0x1111..0x8888 -> OUT=0x4444_3333_2222_1111 then 0x8888_7777_6666_5555, IN_READY never low.
REQ-032 OUT_READY=0 with word pending, 4 more beats offered -> 3 accepted, IN_READY=0 on 4th, OUT unchanged; OUT_READY=1 -> 4th beat accepted, new word loaded next cycle.
REQ-033 Two beats then SOF=1 with beat 0xAAAA -> ALIGN_ERR single-cycle pulse; three further beats 0xBBBB,0xCCCC,0xDDDD -> OUT=0xDDDD_CCCC_BBBB_AAAA.
REQ-034 RST_N low for one cycle after 3 beats -> OUT_VALID=0 and OUT=0 immediately; 4 new beats produce exactly one word built only from post-reset beats.
